// File: rtl/fifo_sync_ctrl_if.sv
// User-side and LSRAM-side signal bundle for the single-clock FIFO controller.
// Optional OVERFLOW/UNDERFLOW exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_sync_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 7
);
  logic             WE;
  logic [WIDTH-1:0] WDATA;
  logic             RE;
  logic [WIDTH-1:0] RDATA;
  logic             DVLD;
  logic             FULL;
  logic             EMPTY;
  logic             AFULL;
  logic             AEMPTY;
  logic [AW:0]      COUNT;
  logic [WIDTH-1:0] RAM_WDATA;
  logic [AW-1:0]    RAM_WADDR;
  logic             RAM_WEN;
  logic [AW-1:0]    RAM_RADDR;
  logic             RAM_REN;
  logic [WIDTH-1:0] RAM_RDATA;
`ifdef FIFO_ERR_FLAGS_EN
  logic             OVERFLOW;
  logic             UNDERFLOW;

  modport slave (
    input  WE, WDATA, RE, RAM_RDATA,
    output RDATA, DVLD, FULL, EMPTY, AFULL, AEMPTY, COUNT,
           RAM_WDATA, RAM_WADDR, RAM_WEN, RAM_RADDR, RAM_REN,
           OVERFLOW, UNDERFLOW
  );
  modport master (
    output WE, WDATA, RE, RAM_RDATA,
    input  RDATA, DVLD, FULL, EMPTY, AFULL, AEMPTY, COUNT,
           RAM_WDATA, RAM_WADDR, RAM_WEN, RAM_RADDR, RAM_REN,
           OVERFLOW, UNDERFLOW
  );
`else
  modport slave (
    input  WE, WDATA, RE, RAM_RDATA,
    output RDATA, DVLD, FULL, EMPTY, AFULL, AEMPTY, COUNT,
           RAM_WDATA, RAM_WADDR, RAM_WEN, RAM_RADDR, RAM_REN
  );
  modport master (
    output WE, WDATA, RE, RAM_RDATA,
    input  RDATA, DVLD, FULL, EMPTY, AFULL, AEMPTY, COUNT,
           RAM_WDATA, RAM_WADDR, RAM_WEN, RAM_RADDR, RAM_REN
  );
`endif
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller in front of an LSRAM: wrap-bit pointers, occupancy,
// registered flags and read-latency-aligned DVLD. FIFO_ERR_FLAGS_EN adds sticky error flags.
module fifo_sync_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 128,
  parameter int AW         = 7,
  parameter int RD_LATENCY = 2,
  parameter int AFULL_TH   = 120,
  parameter int AEMPTY_TH  = 8
) (
  input logic            CLOCK,
  input logic            RESET,
  fifo_sync_ctrl_if.slave bus
);
  localparam int          AW1      = AW + 1;
  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_C  = AW1'(DEPTH);
  localparam logic [AW:0] AFULL_C  = AW1'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_C = AW1'(AEMPTY_TH);

  logic [AW:0]           wptr, rptr, count, count_nxt;
  logic                  full, empty, afull, aempty;
  logic                  push_ok, pop_ok;
  logic [RD_LATENCY-1:0] vld_pipe;

  assign push_ok = bus.WE & ~full;
  assign pop_ok  = bus.RE & ~empty;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  // Flags come from count_nxt so they are exact right after the edge.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      if (push_ok) wptr <= wptr + ONE;
      if (pop_ok)  rptr <= rptr + ONE;
      count  <= count_nxt;
      full   <= (count_nxt == DEPTH_C);
      empty  <= (count_nxt == '0);
      afull  <= (count_nxt >= AFULL_C);
      aempty <= (count_nxt <= AEMPTY_C);
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) vld_pipe <= '0;
        else       vld_pipe <= pop_ok;
      end
    end else begin : g_latn
      always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[RD_LATENCY-2:0], pop_ok};
      end
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow, underflow;
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow  | (bus.WE & full);
      underflow <= underflow | (bus.RE & empty);
    end
  end
  assign bus.OVERFLOW  = overflow;
  assign bus.UNDERFLOW = underflow;
`endif

  assign bus.RAM_WEN   = push_ok;
  assign bus.RAM_REN   = pop_ok;
  assign bus.RAM_WADDR = wptr[AW-1:0];
  assign bus.RAM_RADDR = rptr[AW-1:0];
  assign bus.RAM_WDATA = bus.WDATA;
  assign bus.RDATA     = bus.RAM_RDATA;
  assign bus.DVLD      = vld_pipe[RD_LATENCY-1];
  assign bus.COUNT     = count;
  assign bus.FULL      = full;
  assign bus.EMPTY     = empty;
  assign bus.AFULL     = afull;
  assign bus.AEMPTY    = aempty;
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Randomized bench for fifo_sync_ctrl: queue-based FIFO model plus a behavioural LSRAM.
module tb_fifo_sync_ctrl;
  localparam int WIDTH = 32, DEPTH = 128, AW = 7, RDL = 2, AFT = 120, AET = 8;

  logic CLOCK = 1'b0;
  logic RESET;
  always #5 CLOCK = ~CLOCK;

  fifo_sync_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  fifo_sync_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .RD_LATENCY(RDL),
    .AFULL_TH(AFT), .AEMPTY_TH(AET)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus  (bus)
  );

  // LSRAM with a two-cycle registered read path
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_s1, rd_s2;
  always @(posedge CLOCK) begin
    if (bus.RAM_WEN) mem[bus.RAM_WADDR] <= bus.RAM_WDATA;
    if (bus.RAM_REN) rd_s1 <= mem[bus.RAM_RADDR];
    rd_s2 <= rd_s1;
  end
  assign bus.RAM_RDATA = rd_s2;

  typedef struct { logic [WIDTH-1:0] d; int due; } pend_t;
  logic [WIDTH-1:0] q[$];
  pend_t            pend[$];
  int  cyc, wcnt, rcnt, checks, failures;
  bit  ovf, unf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_regs();
    bit dv;
    chk("count",  bus.COUNT,  q.size());
    chk("full",   bus.FULL,   q.size() == DEPTH);
    chk("empty",  bus.EMPTY,  q.size() == 0);
    chk("afull",  bus.AFULL,  q.size() >= AFT);
    chk("aempty", bus.AEMPTY, q.size() <= AET);
    dv = (pend.size() > 0) && (pend[0].due == cyc);
    chk("dvld", bus.DVLD, dv);
    if (dv) begin
      chk("rdata", bus.RDATA, pend[0].d);
      void'(pend.pop_front());
    end
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow",  bus.OVERFLOW,  ovf);
    chk("underflow", bus.UNDERFLOW, unf);
`endif
  endtask

  task automatic step(input bit we, input bit re, input logic [WIDTH-1:0] d);
    bit wok, rok;
    @(negedge CLOCK);
    bus.WE = we; bus.RE = re; bus.WDATA = d;
    #1;
    wok = we && (q.size() < DEPTH);
    rok = re && (q.size() > 0);
    chk("ram_wen",   bus.RAM_WEN,   wok);
    chk("ram_ren",   bus.RAM_REN,   rok);
    chk("ram_waddr", bus.RAM_WADDR, wcnt % DEPTH);
    chk("ram_raddr", bus.RAM_RADDR, rcnt % DEPTH);
    chk("ram_wdata", bus.RAM_WDATA, d);
    @(posedge CLOCK);
    cyc++;
    if (we && q.size() == DEPTH) ovf = 1;
    if (re && q.size() == 0)     unf = 1;
    if (rok) begin
      pend.push_back('{q.pop_front(), cyc + RDL - 1});
      rcnt++;
    end
    if (wok) begin
      q.push_back(d);
      wcnt++;
    end
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    bus.WE = 0; bus.RE = 0;
    RESET = 1'b1;
    #1;
    q.delete(); pend.delete();
    wcnt = 0; rcnt = 0; ovf = 0; unf = 0;
    check_regs();
    repeat (2) @(posedge CLOCK) cyc++;
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0);
  endtask

  initial begin
    RESET = 1'b1;
    bus.WE = 0; bus.RE = 0; bus.WDATA = '0;
    checks = 0; failures = 0; cyc = 0;

    // reset and idle
    do_reset();
    idle(3);

    // fill to full, then one rejected push
    for (int i = 0; i < DEPTH; i++) step(1, 0, i);
    step(1, 0, 32'h0BAD_0BAD);
    // drain in order, then one rejected pop
    for (int i = 0; i < DEPTH; i++) step(0, 1, '0);
    step(0, 1, '0);
    idle(4);

    // simultaneous push+pop at full and at empty
    for (int i = 0; i < DEPTH; i++) step(1, 0, $urandom);
    step(1, 1, 32'hDEAD_BEEF);
    while (q.size() > 0) step(0, 1, '0);
    idle(3);
    step(1, 1, 32'hCAFE_F00D);
    idle(3);

    // steady half-full streaming across the address wrap
    while (q.size() < 64) step(1, 0, $urandom);
    for (int i = 0; i < 300; i++) step(1, 1, $urandom);
    idle(3);

    // random traffic, biased phases to visit both ends
    for (int ph = 0; ph < 6; ph++) begin
      int pw = (ph % 2 == 0) ? 80 : 20;
      for (int i = 0; i < 400; i++)
        step($urandom_range(99) < pw, $urandom_range(99) < (100 - pw), $urandom);
    end
    idle(4);

    // reset with a pop in flight; includes an underflow beforehand
    do_reset();
    step(0, 1, '0);
    step(1, 0, 32'h1111_1111);
    step(1, 0, 32'h2222_2222);
    step(0, 1, '0);
    do_reset();
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
